// File: rtl/uart_pkg.sv
// Shared types and frame constants for the 8N1 UART core and its receiver.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser, 8N1 deserialiser and single-byte holding register.
//  state    | meaning
//  RX_IDLE  | line idle, waiting for a low level
//  RX_START | half-bit wait, then confirm the start bit (high = glitch)
//  RX_DATA  | sample 8 data bits at mid-bit, LSB first
//  RX_STOP  | sample the stop bit; high loads the holding register
//  RX_BREAK | framing error, wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       overrun
);

    localparam int DW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [DW-1:0] BIT_LAST  = DW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     rx_state;
    logic [1:0]    rx_sync;
    logic          rx_s;
    logic [DW-1:0] rx_div;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          stop_ok;

    assign rx_s    = rx_sync[1];
    assign stop_ok = (rx_state == RX_STOP) && (rx_div == '0) && rx_s;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_div   <= HALF_LAST;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_div != '0) begin
                        rx_div <= rx_div - DW'(1);
                    end else if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_div   <= BIT_LAST;
                        rx_bit   <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_div != '0) begin
                        rx_div <= rx_div - DW'(1);
                    end else begin
                        rx_div   <= BIT_LAST;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'(DATA_BITS - 1)) begin
                            rx_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_div != '0) begin
                        rx_div <= rx_div - DW'(1);
                    end else begin
                        rx_state <= rx_s ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A byte landing in the same cycle as rd replaces the acknowledged one without overrun.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (stop_ok) begin
            data    <= rx_shift;
            valid   <= 1'b1;
            overrun <= (overrun || valid) && !rd;
        end else if (rd) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART peripheral: inline transmitter plus uart_rx receiver, independent bit timing.
//  state    | meaning
//  TX_IDLE  | txd high, accepting a write
//  TX_START | driving the start bit
//  TX_DATA  | shifting 8 data bits out, LSB first
//  TX_STOP  | driving the stop bit, busy drops at its end
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       uart0_wr,
    input  logic [7:0] uart_w,
    input  logic       uart0_rd,
    output logic [7:0] uart0_data,
    output logic       uart0_valid,
    output logic       uart0_busy,
    output logic       uart0_overrun,
    output logic       uart0_txd,
    input  logic       uart0_rxd
);

    localparam int DW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [DW-1:0] BIT_LAST = DW'(CLKS_PER_BIT - 1);

    tx_state_t     tx_state;
    logic [DW-1:0] tx_div;
    logic [3:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_busy;
    logic          tx_line;

    assign uart0_busy = tx_busy;
    assign uart0_txd  = tx_line;

    // tx_bit tracks position within the frame: 0 start, 1..8 data, 9 stop.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= TX_IDLE;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (uart0_wr && !tx_busy) begin
                        tx_shift <= uart_w;
                        tx_busy  <= 1'b1;
                        tx_line  <= 1'b0;
                        tx_div   <= BIT_LAST;
                        tx_bit   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_div != '0) begin
                        tx_div <= tx_div - DW'(1);
                    end else begin
                        tx_div   <= BIT_LAST;
                        tx_line  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= 4'd1;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_div != '0) begin
                        tx_div <= tx_div - DW'(1);
                    end else begin
                        tx_div <= BIT_LAST;
                        if (tx_bit == 4'(DATA_BITS)) begin
                            tx_line  <= 1'b1;
                            tx_bit   <= 4'(FRAME_BITS - 1);
                            tx_state <= TX_STOP;
                        end else begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_div != '0) begin
                        tx_div <= tx_div - DW'(1);
                    end else begin
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .resetq (resetq),
        .rxd    (uart0_rxd),
        .rd     (uart0_rd),
        .data   (uart0_data),
        .valid  (uart0_valid),
        .overrun(uart0_overrun)
    );

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: TX frames decoded by a line monitor, RX bytes checked at the holding register.
module tb_uart_core;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       uart0_wr = 1'b0;
    logic [7:0] uart_w = 8'h00;
    logic       uart0_rd = 1'b0;
    logic [7:0] uart0_data;
    logic       uart0_valid;
    logic       uart0_busy;
    logic       uart0_overrun;
    logic       uart0_txd;
    logic       uart0_rxd;
    logic       tb_rxd = 1'b1;
    logic       loop_en = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int rst_cnt = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    assign uart0_rxd = loop_en ? uart0_txd : tb_rxd;

    always #5 clk = ~clk;
    always @(negedge resetq) rst_cnt++;

    uart_core #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .resetq       (resetq),
        .uart0_wr     (uart0_wr),
        .uart_w       (uart_w),
        .uart0_rd     (uart0_rd),
        .uart0_data   (uart0_data),
        .uart0_valid  (uart0_valid),
        .uart0_busy   (uart0_busy),
        .uart0_overrun(uart0_overrun),
        .uart0_txd    (uart0_txd),
        .uart0_rxd    (uart0_rxd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frames interrupted by reset are dropped from the scoreboard instead of compared.
    initial begin : tx_mon
        logic [9:0] fr;
        int r0;
        @(posedge resetq);
        forever begin
            @(negedge clk);
            if (uart0_txd === 1'b0 && resetq === 1'b1) begin
                r0 = rst_cnt;
                repeat (CPB / 2) @(negedge clk);
                fr[0] = uart0_txd;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(negedge clk);
                    fr[i] = uart0_txd;
                end
                if (rst_cnt != r0) begin
                    if (tx_q.size() > 0) tx_q.delete(0);
                end else if (tx_q.size() == 0) begin
                    chk("tx_unexpected_frame", tx_q.size(), 1);
                end else begin
                    chk("tx_frame", fr, {1'b1, tx_q.pop_front(), 1'b0});
                end
            end
        end
    end

    task automatic tx_frame_timed(input logic [7:0] b, input int inject_at, input logic [7:0] junk);
        int cnt;
        int bad;
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        @(negedge clk);
        uart0_wr = 1'b1;
        uart_w = b;
        tx_q.push_back(b);
        @(negedge clk);
        uart0_wr = 1'b0;
        chk("tx_busy_after_wr", uart0_busy, 1);
        cnt = 0;
        bad = 0;
        while (uart0_busy && cnt < 400) begin
            if (cnt < 10 * CPB && uart0_txd !== fr[cnt / CPB]) bad++;
            if (cnt == inject_at) begin
                uart0_wr = 1'b1;
                uart_w = junk;
            end else begin
                uart0_wr = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        uart0_wr = 1'b0;
        chk("tx_waveform_errors", bad, 0);
        chk("tx_busy_cycles", cnt, 10 * CPB);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        tb_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            tb_rxd = b[i];
            tick(CPB);
        end
        tb_rxd = stop_bit;
        tick(CPB);
        tb_rxd = 1'b1;
    endtask

    // Newest pushed byte is the one the holding register must show; older ones were overwritten.
    task automatic rx_expect(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        while (!uart0_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, uart0_valid, 1);
        if (rx_q.size() == 0) begin
            chk({tag, "_sb_empty"}, rx_q.size(), 1);
        end else begin
            e = rx_q[$];
            rx_q.delete();
            chk({tag, "_data"}, uart0_data, e);
        end
    endtask

    task automatic rd_pulse();
        @(negedge clk);
        uart0_rd = 1'b1;
        @(negedge clk);
        uart0_rd = 1'b0;
    endtask

    initial begin : main
        int n;
        tick(3);
        chk("rst_txd", uart0_txd, 1);
        chk("rst_busy", uart0_busy, 0);
        chk("rst_valid", uart0_valid, 0);
        chk("rst_overrun", uart0_overrun, 0);
        chk("rst_data", uart0_data, 0);
        resetq = 1'b1;
        tick(3);

        tx_frame_timed(8'h55, -1, 8'h00);
        tick(5);

        tx_frame_timed(8'hA3, 50, 8'h7E);
        tick(40);
        chk("tx_no_refire", uart0_busy, 0);
        tick(5);
        chk("tx_sb_drained", tx_q.size(), 0);

        rx_q.push_back(8'hC4);
        rx_send(8'hC4, 1'b1);
        rx_expect("rx_c4");
        chk("rx_c4_overrun", uart0_overrun, 0);
        rd_pulse();
        chk("rx_c4_rd_valid", uart0_valid, 0);
        chk("rx_c4_rd_data", uart0_data, 8'hC4);

        rx_q.push_back(8'h11);
        rx_send(8'h11, 1'b1);
        rx_q.push_back(8'h22);
        rx_send(8'h22, 1'b1);
        rx_expect("rx_ovr");
        chk("rx_ovr_flag", uart0_overrun, 1);
        rd_pulse();
        chk("rx_ovr_rd_valid", uart0_valid, 0);
        chk("rx_ovr_rd_flag", uart0_overrun, 0);

        tb_rxd = 1'b0;
        tick(5);
        tb_rxd = 1'b1;
        tick(40);
        chk("rx_glitch_valid", uart0_valid, 0);
        rx_send(8'h3C, 1'b0);
        tick(20);
        chk("rx_ferr_valid", uart0_valid, 0);
        chk("rx_ferr_overrun", uart0_overrun, 0);
        chk("rx_ferr_data", uart0_data, 8'h22);
        rx_q.push_back(8'h5A);
        rx_send(8'h5A, 1'b1);
        rx_expect("rx_after_ferr");
        rd_pulse();

        loop_en = 1'b1;
        tick(2);
        uart0_wr = 1'b1;
        uart_w = 8'h96;
        tx_q.push_back(8'h96);
        @(negedge clk);
        uart0_wr = 1'b0;
        tick(70);
        #3 resetq = 1'b0;
        #1;
        chk("rst_mid_txd", uart0_txd, 1);
        chk("rst_mid_busy", uart0_busy, 0);
        chk("rst_mid_valid", uart0_valid, 0);
        tick(3);
        resetq = 1'b1;
        tick(200);

        rx_q.push_back(8'h96);
        tx_q.push_back(8'h96);
        uart0_wr = 1'b1;
        uart0_rd = 1'b1;
        uart_w = 8'h96;
        @(negedge clk);
        uart0_wr = 1'b0;
        uart0_rd = 1'b0;
        rx_expect("loop");
        n = 0;
        while (uart0_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("loop_busy_done", uart0_busy, 0);
        tick(10);
        chk("loop_tx_sb_drained", tx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- 8N1 UART peripheral that sits on the far side of the CPU I/O decoder's UART strobes (io address bit 12).
- Accepts a write strobe plus a byte and serialises it on the TX pin.
- Deserialises the RX pin into a single-byte holding register.
- Reports TX-ready and RX-valid status for the misc.in status word.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; legal range 4..65535; sim default 16, board value clk/baud.

Ports:
clk  input  1  system clock
resetq  input  1  asynchronous active-low reset
uart0_wr  input  1  one-cycle write strobe; transmit uart_w
uart_w  input  8  byte to transmit, sampled when uart0_wr=1
uart0_rd  input  1  one-cycle read strobe; acknowledges the RX byte
uart0_data  output  8  last received byte (registered)
uart0_valid  output  1  RX holding register full
uart0_busy  output  1  transmitter occupied
uart0_overrun  output  1  sticky: a byte arrived while uart0_valid=1
uart0_txd  output  1  serial out, idle high
uart0_rxd  input  1  serial in, asynchronous to clk

Behaviour:
- Clocking and reset: one clock, clk. Reset is resetq, asynchronous and active-low.
- Reset values: uart0_txd=1, uart0_busy=0, uart0_valid=0, uart0_overrun=0, uart0_data=0. Both FSMs go to IDLE. Bit counters and divisors are 0. RX synchroniser flops are 1.
- Reset mid-frame: TX aborts with txd forced to 1 immediately. A partial RX byte is discarded.
- Divisor: each FSM has its own counter, width $clog2(CLKS_PER_BIT+1). There is no shared baud tick, so TX and RX phase independently.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE to START: on uart0_wr && !uart0_busy. Latch uart_w into the shift register and set busy=1 in the same edge. txd drives 0 from the next cycle.
  - START: lasts CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE with busy=0.
  - Total busy time is exactly 10*CLKS_PER_BIT cycles.
  - uart0_wr while busy is ignored: the byte is dropped and the frame in flight is unaffected.
  - A back-to-back write on the first cycle busy=0 starts a new frame with no gap beyond the stop bit.
- RX synchroniser: uart0_rxd passes through two flops before any use.
- RX FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE to START: on synchronised rxd=0.
  - START: wait CLKS_PER_BIT/2 (integer division), then resample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit, 8 samples, LSB first.
  - STOP: sample once after CLKS_PER_BIT.
    - Sample = 1: load uart0_data, set uart0_valid=1, return to IDLE.
    - Sample = 0: framing error. Discard the byte, leave data, valid and overrun unchanged, go to BREAK.
  - BREAK: wait for synchronised rxd=1, then IDLE.
- RX holding register:
  - uart0_rd with valid=1: valid=0 and overrun=0 on the next edge. uart0_data is not cleared.
  - uart0_rd with valid=0: clears overrun only.
  - Byte completes while valid=1 and no rd: data is overwritten, valid stays 1, overrun is set.
  - Byte completes in the same cycle as rd: the new byte wins. Data updates, valid stays 1, overrun=0.
- Latency: the byte is visible 1 cycle after the stop-bit mid-sample edge. uart0_data is stable for the whole cycle rd is asserted.
- TX and RX are fully independent. A loopback of txd to rxd must work, including simultaneous wr and rd.

Decomposition:
- Shared package uart_pkg holds:
  - typedefs tx_state_t {IDLE,START,DATA,STOP} and rx_state_t {IDLE,START,DATA,STOP,BREAK};
  - constant DATA_BITS=8;
  - constant FRAME_BITS=10.
- Sub-module uart_rx contains the synchroniser, RX FSM and holding/overrun logic. It exposes the three RX ports and the rd strobe.
- The TX FSM stays inline in uart_core.

Test Plan (CLKS_PER_BIT=16):
1. Reset, then wr with uart_w=0x55 → busy=1 next cycle. txd shows 0,1,0,1,0,1,0,1,0,1, each bit held 16 cycles. busy=0 exactly 160 cycles after the strobe.
2. wr 0xA3, then wr 0x7E at cycle 50 → 0x7E is ignored. Only the frame for 0xA3 appears, and busy has one 160-cycle span.
3. Drive an rxd frame for 0xC4 → valid=1 and data=0xC4 one cycle after the stop mid-sample. rd → valid=0 next cycle, data still 0xC4.
4. Two frames 0x11 then 0x22 with no rd → data=0x22, valid=1, overrun=1. rd → valid=0 and overrun=0.
5. rxd low pulse of 5 cycles → no valid, FSM back in IDLE. Frame 0x3C with stop bit 0 → no valid. A frame sent after rxd returns high is received correctly.
6. Loopback txd to rxd and wr 0x96; assert resetq=0 mid-frame once → txd=1 and busy=0 immediately. After reset, wr 0x96 again → valid=1, data=0x96.
